// File: rtl/cic_host_mem.sv
// Host-side responder for the CNN convolution core (CIC).
// Holds the image memory, runs the ready/busy start handshake, serves the
// core's image reads and its reads/writes to the five layer banks.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   load_en/addr/data      host writes into image memory (idle only)
//   start                  begin handshake; clears err and wcnt
//   ready (out), busy (in) handshake with the core
//   iaddr, idata           image read, one-cycle registered latency
//   crd, caddr_rd, cdata_rd layer read (any state)
//   cwr, caddr_wr, cdata_wr layer write (run state only)
//   csel                   bank: 1 L0K0, 2 L0K1, 3 L1K0, 4 L1K1, 5 L2
//   done                   one-cycle pulse when the core finishes
//   err                    sticky access-error flag
//   wcnt                   saturating count of accepted layer writes
module cic_host_mem #(
  parameter int unsigned DW        = 20,
  parameter int unsigned AW        = 12,
  parameter int unsigned IMG_DEPTH = 4096,
  parameter int unsigned L0_DEPTH  = 4096,
  parameter int unsigned L1_DEPTH  = 1024,
  parameter int unsigned L2_DEPTH  = 2048
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic [2:0]    csel,
  output logic          done,
  output logic          err,
  output logic [15:0]   wcnt
);

  localparam int unsigned ImgW = $clog2(IMG_DEPTH);
  localparam int unsigned L0W  = $clog2(L0_DEPTH);
  localparam int unsigned L1W  = $clog2(L1_DEPTH);
  localparam int unsigned L2W  = $clog2(L2_DEPTH);

  typedef enum logic [1:0] {StIdle, StReady, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [DW-1:0] img_mem  [IMG_DEPTH];
  logic [DW-1:0] l0k0_mem [L0_DEPTH];
  logic [DW-1:0] l0k1_mem [L0_DEPTH];
  logic [DW-1:0] l1k0_mem [L1_DEPTH];
  logic [DW-1:0] l1k1_mem [L1_DEPTH];
  logic [DW-1:0] l2_mem   [L2_DEPTH];

  logic in_idle, in_run, img_rd_en;
  logic load_ok, load_err, img_rd_ok, img_rd_err, start_clr;
  logic sel_none, sel_valid, wr_in_range, rd_in_range;
  logic wr_ok, wr_err, rd_err;
  logic [DW-1:0] rd_word;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StReady;
      StReady: if (busy)  state_d = StRun;
      StRun:   if (!busy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready = (state_q == StReady);
    done  = (state_q == StDone);
  end

  assign in_idle   = (state_q == StIdle);
  assign in_run    = (state_q == StRun);
  assign img_rd_en = (state_q == StReady) || in_run;
  assign start_clr = in_idle && start;

  assign load_ok    = in_idle && load_en && (32'(load_addr) < IMG_DEPTH);
  assign load_err   = in_idle && load_en && (32'(load_addr) >= IMG_DEPTH);
  assign img_rd_ok  = 32'(iaddr) < IMG_DEPTH;
  assign img_rd_err = img_rd_en && !img_rd_ok;

  // Bank decode; read and write share csel. Out-of-range indices alias but
  // the result is masked by the range flags.
  always_comb begin
    wr_in_range = 1'b0;
    rd_in_range = 1'b0;
    rd_word     = '0;
    case (csel)
      3'd1: begin
        wr_in_range = 32'(caddr_wr) < L0_DEPTH;
        rd_in_range = 32'(caddr_rd) < L0_DEPTH;
        rd_word     = l0k0_mem[caddr_rd[L0W-1:0]];
      end
      3'd2: begin
        wr_in_range = 32'(caddr_wr) < L0_DEPTH;
        rd_in_range = 32'(caddr_rd) < L0_DEPTH;
        rd_word     = l0k1_mem[caddr_rd[L0W-1:0]];
      end
      3'd3: begin
        wr_in_range = 32'(caddr_wr) < L1_DEPTH;
        rd_in_range = 32'(caddr_rd) < L1_DEPTH;
        rd_word     = l1k0_mem[caddr_rd[L1W-1:0]];
      end
      3'd4: begin
        wr_in_range = 32'(caddr_wr) < L1_DEPTH;
        rd_in_range = 32'(caddr_rd) < L1_DEPTH;
        rd_word     = l1k1_mem[caddr_rd[L1W-1:0]];
      end
      3'd5: begin
        wr_in_range = 32'(caddr_wr) < L2_DEPTH;
        rd_in_range = 32'(caddr_rd) < L2_DEPTH;
        rd_word     = l2_mem[caddr_rd[L2W-1:0]];
      end
      default: ;
    endcase
  end

  assign sel_none  = (csel == 3'd0);
  assign sel_valid = (csel >= 3'd1) && (csel <= 3'd5);
  assign wr_ok     = in_run && cwr && sel_valid && wr_in_range;
  // csel 000 is a quiet no-op for both directions
  assign wr_err    = cwr && !sel_none && !(in_run && sel_valid && wr_in_range);
  assign rd_err    = crd && !sel_none && !(sel_valid && rd_in_range);

  // Memories have no reset; contents survive it. Reads above happen before
  // these writes land, giving read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (load_ok) img_mem[load_addr[ImgW-1:0]] <= load_data;
    if (wr_ok) begin
      case (csel)
        3'd1:    l0k0_mem[caddr_wr[L0W-1:0]] <= cdata_wr;
        3'd2:    l0k1_mem[caddr_wr[L0W-1:0]] <= cdata_wr;
        3'd3:    l1k0_mem[caddr_wr[L1W-1:0]] <= cdata_wr;
        3'd4:    l1k1_mem[caddr_wr[L1W-1:0]] <= cdata_wr;
        3'd5:    l2_mem[caddr_wr[L2W-1:0]]   <= cdata_wr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idata    <= '0;
      cdata_rd <= '0;
      wcnt     <= '0;
      err      <= 1'b0;
    end else begin
      if (img_rd_en) idata <= img_rd_ok ? img_mem[iaddr[ImgW-1:0]] : '0;
      if (crd) cdata_rd <= (sel_valid && rd_in_range) ? rd_word : '0;
      if (start_clr)                   wcnt <= '0;
      else if (wr_ok && wcnt != 16'hFFFF) wcnt <= wcnt + 16'd1;
      // Start clears history; errors raised in the same cycle still stick.
      err <= (err && !start_clr) || load_err || img_rd_err || wr_err || rd_err;
    end
  end

endmodule

// File: doc/cic_host_mem.md
Name: cic_host_mem

Overview:
- Host-side responder for the CNN convolution core (CIC).
- Holds the grey-level image memory and runs the ready/busy start handshake.
- Answers the core's iaddr/idata image reads, and its crd/cwr reads and writes to the five layer memories selected by csel.
- Sits between the testbench/host loader and the core. It is the memory end of the interface the core initiates.

Parameters:
- DW, 20, data width of image and layer words.
- AW, 12, address width of iaddr, caddr_rd and caddr_wr.
- IMG_DEPTH, 4096, words of image memory (64x64).
- L0_DEPTH, 4096, words in each Layer-0 bank (csel 001, 010).
- L1_DEPTH, 1024, words in each Layer-1 bank (csel 011, 100).
- L2_DEPTH, 2048, words in the Layer-2 flatten bank (csel 101).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  host write strobe into image memory.
- load_addr  in  AW  image write address.
- load_data  in  DW  image write data.
- start  in  1  single-cycle pulse: image loaded, begin the handshake.
- ready  out  1  to core: image ready.
- busy  in  1  from core: fetch/compute in progress.
- iaddr  in  AW  image read address.
- idata  out  DW  image read data.
- crd  in  1  layer read enable.
- caddr_rd  in  AW  layer read address.
- cdata_rd  out  DW  layer read data.
- cwr  in  1  layer write enable.
- caddr_wr  in  AW  layer write address.
- cdata_wr  in  DW  layer write data.
- csel  in  3  bank select: 000 none, 001 L0K0, 010 L0K1, 011 L1K0, 100 L1K1, 101 L2; 110 and 111 invalid.
- done  out  1  one-cycle pulse when the core finishes.
- err  out  1  sticky access-error flag.
- wcnt  out  16  count of accepted layer writes.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to S_IDLE.
  - ready=0, done=0, err=0, wcnt=0, idata=0, cdata_rd=0.
  - Memory arrays are not cleared; contents survive a reset.
- FSM states: S_IDLE, S_READY, S_RUN, S_DONE.
- S_IDLE:
  - load_en writes load_data to image[load_addr].
  - load_addr >= IMG_DEPTH is ignored and sets err.
  - start moves the FSM to S_READY and clears err and wcnt in the same cycle.
- S_READY:
  - ready=1.
  - busy sampled 1 moves the FSM to S_RUN; ready is 0 from the next cycle.
  - start and load_en are ignored.
- S_RUN:
  - ready=0.
  - busy sampled 0 moves the FSM to S_DONE.
  - load_en and start are ignored.
- S_DONE: done=1 for exactly one cycle, then the FSM returns to S_IDLE.
- Image read:
  - In S_READY and S_RUN, idata <= image[iaddr] every cycle (one-cycle latency, registered).
  - In other states idata holds its value.
  - iaddr >= IMG_DEPTH returns 0 and sets err.
- Layer write:
  - Accepted only in S_RUN when cwr=1, csel is valid (001..101) and caddr_wr < the selected bank's depth.
  - Each accepted write increments wcnt. wcnt saturates at 16'hFFFF.
  - cwr with csel=000 is ignored with no error.
  - cwr with csel=110/111, an out-of-range address, or outside S_RUN is ignored and sets err.
- Layer read:
  - Allowed in any state, so the host can dump results after done.
  - crd=1 gives cdata_rd <= bank[caddr_rd] next cycle.
  - Invalid csel, csel=000 or an out-of-range address returns 0; only invalid csel or an out-of-range address sets err.
  - With crd=0, cdata_rd holds.
- Simultaneous crd and cwr to the same bank and address: read-first; cdata_rd returns the old word and the write lands.
- crd and cwr in one cycle share one csel; both apply to that bank.
- err, once set, stays set until reset or start in S_IDLE.
- Reset mid-S_RUN: FSM returns to S_IDLE, ready=0, and no done is produced.

Test Plan:
- Load image[0]=20'h00A5, image[4095]=20'h0FFFF, then pulse start. Expect ready=1 next cycle. Drive busy=1; ready falls 1 cycle later. iaddr=4095 gives idata=20'h0FFFF the following cycle.
- In S_RUN with csel=001, write 20'h12345 at 0x040, then crd at 0x040. Expect cdata_rd=20'h12345 and wcnt=1. The same read with csel=010 returns the L0K1 contents, not 20'h12345.
- In S_RUN, cwr with csel=011 and caddr_wr=1024. Expect the write dropped, err=1, wcnt unchanged. A later start in S_IDLE clears err to 0.
- Same-cycle crd and cwr at L2 address 0x7FF (old 0, new 20'hABCDE). Expect cdata_rd=0 that cycle; a read next cycle gives 20'hABCDE.
- Drop busy to 0 in S_RUN. Expect done=1 for exactly one cycle, then ready=0 in S_IDLE, and L0K0[0x040] still readable as 20'h12345.
- Assert reset mid-S_RUN. Expect ready=0, done never pulses, wcnt=0, and image memory contents preserved on re-run.
